// File: rtl/ecc_bist_if.sv
// Codec-side bus of the ECC self-test engine: data to the encoder,
// corrupted codeword to the decoder, decoded data and flags back.
interface ecc_bist_if #(
    parameter int K  = 72,
    parameter int CW = 80
);
    logic [K-1:0]  enc_d_o;
    logic [CW-1:0] enc_q_i;
    logic [CW-1:0] ch_q_o;
    logic [K-1:0]  dec_q_i;
    logic          sb_err_i;
    logic          db_err_i;
    logic          sb_fix_i;

    modport master (
        output enc_d_o,
        output ch_q_o,
        input  enc_q_i,
        input  dec_q_i,
        input  sb_err_i,
        input  db_err_i,
        input  sb_fix_i
    );

    modport slave (
        input  enc_d_o,
        input  ch_q_o,
        output enc_q_i,
        output dec_q_i,
        output sb_err_i,
        output db_err_i,
        output sb_fix_i
    );
endinterface

// File: rtl/ecc_bist.sv
// Self-test engine for a Hamming SEC-DED encoder/decoder pair: issues
// data words, flips 0/1/2 codeword bits and scores the decoder replies.
module ecc_bist #(
    parameter int          K           = 72,
    parameter int          P0_LSB      = 0,
    parameter int          DEC_LATENCY = 0,
    parameter int          RUNS_W      = 24,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] SEED        = 32'hACE1_2468
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [2:0]        mode_i,
    input  logic [RUNS_W-1:0] runs_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  good_o,
    output logic [CNT_W-1:0]  bad_o,
    output logic [RUNS_W-1:0] fail_idx_o,
    ecc_bist_if.master        ecc
);
    function automatic int calc_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < m + k + 1) m++;
        return m;
    endfunction

    localparam int M   = calc_m(K);
    localparam int N   = M + K;
    localparam int CW  = N + 1;
    localparam int FW  = $clog2(CW);
    localparam int FW1 = FW + 1;
    localparam int REP = (K + 31) / 32;
    localparam logic [31:0] POLY = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              valid;
        logic [K-1:0]      data;
        logic [1:0]        nflips;
        logic              info;
        logic [RUNS_W-1:0] idx;
    } exp_t;

    state_t            state, state_n;
    logic              go, issue, last, zero_run;
    logic [2:0]        mode_q;
    logic [RUNS_W-1:0] runs_q, idx;
    logic [FW-1:0]     f1, f2, f1_n, f2_n;
    logic [FW1-1:0]    f2_inc;
    logic [31:0]       lfsr, lfsr_n, p1, p2;
    logic [FW-1:0]     r1, r2, rf, flip1, flip2;
    logic [2:0]        dcnt;
    logic [K-1:0]      enc_d, data_n, seq_d, rnd_d;
    logic [CW-1:0]     mask, mask_n, m1, m2;
    logic [1:0]        nf_n;
    logic              info_n, data_ok, ok, done_q;
    logic [CNT_W-1:0]  good, bad;
    logic [RUNS_W-1:0] fail_idx;
    exp_t              exp_n, chk;
    exp_t              pipe [DEC_LATENCY+1];

    // A flipped bit carries data unless it is P0 or a power-of-two position.
    function automatic logic is_info(input logic [FW-1:0] b);
        logic [FW1-1:0] pos;
        pos = (P0_LSB != 0) ? {1'b0, b} : {1'b0, b} + 1'b1;
        if (P0_LSB != 0)
            return (b != '0) && ((pos & (pos - 1'b1)) != '0);
        return (b != FW'(N)) && ((pos & (pos - 1'b1)) != '0);
    endfunction

    assign zero_run = (runs_i == '0) && (mode_i != 3'd2)
                    && (mode_i != 3'd4);

    always_comb begin
        state_n = state;
        go      = 1'b0;
        issue   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    go      = 1'b1;
                    state_n = zero_run ? DONE : RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (last) state_n = DRAIN;
            end
            DRAIN: begin
                if (dcnt == 3'(DEC_LATENCY)) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        lfsr_n = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
        p1     = {16'd0, lfsr[15:0]} * 32'(CW);
        p2     = {16'd0, lfsr[31:16]} * 32'(CW - 1);
        r1     = FW'(p1 >> 16);
        rf     = FW'(p2 >> 16);
        r2     = rf + FW'(rf >= r1);
        seq_d  = K'(idx);
        rnd_d  = K'({REP{lfsr}});
    end

    // Double-flip walk: outer f1, inner f2 stepping over f1.
    always_comb begin
        f2_inc = {1'b0, f2} + 1'b1;
        if (f2_inc == {1'b0, f1}) f2_inc = {1'b0, f2} + FW1'(2);
        f1_n = f1;
        f2_n = f2_inc[FW-1:0];
        if (f2_inc >= FW1'(CW)) begin
            f1_n = f1 + 1'b1;
            f2_n = '0;
        end
    end

    always_comb begin
        data_n = rnd_d;
        nf_n   = 2'd0;
        flip1  = r1;
        flip2  = r2;
        unique case (mode_q)
            3'd0: data_n = seq_d;
            3'd2: begin
                data_n = seq_d;
                nf_n   = 2'd1;
                flip1  = idx[FW-1:0];
            end
            3'd3: nf_n = 2'd1;
            3'd4: begin
                data_n = seq_d;
                nf_n   = 2'd2;
                flip1  = f1;
                flip2  = f2;
            end
            3'd5: nf_n = 2'd2;
            3'd6: nf_n = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
            default: nf_n = 2'd0;
        endcase
        m1     = CW'(1) << flip1;
        m2     = CW'(1) << flip2;
        mask_n = (nf_n == 2'd0) ? '0 : (nf_n == 2'd1) ? m1 : (m1 | m2);
        info_n = is_info(flip1);
    end

    always_comb begin
        if (mode_q == 3'd2)
            last = idx == RUNS_W'(CW - 1);
        else if (mode_q == 3'd4)
            last = (f1 == FW'(CW - 1)) && (f2 == FW'(CW - 2));
        else
            last = idx == runs_q - 1'b1;
    end

    always_comb begin
        exp_n        = '0;
        exp_n.valid  = issue;
        exp_n.data   = data_n;
        exp_n.nflips = nf_n;
        exp_n.info   = info_n;
        exp_n.idx    = idx;
    end

    assign chk     = pipe[DEC_LATENCY];
    assign data_ok = ecc.dec_q_i == chk.data;

    always_comb begin
        unique case (chk.nflips)
            2'd1: ok = data_ok & ecc.sb_err_i & ~ecc.db_err_i
                     & (ecc.sb_fix_i == chk.info);
            2'd2: ok = ecc.db_err_i & ~ecc.sb_err_i & ~ecc.sb_fix_i;
            default: ok = data_ok & ~ecc.sb_err_i & ~ecc.db_err_i
                        & ~ecc.sb_fix_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    // Expectations travel alongside the decoder pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i <= DEC_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= exp_n;
            for (int i = 1; i <= DEC_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q   <= '0;
            runs_q   <= '0;
            idx      <= '0;
            f1       <= '0;
            f2       <= '0;
            lfsr     <= SEED;
            dcnt     <= '0;
            enc_d    <= '0;
            mask     <= '0;
            done_q   <= 1'b0;
            good     <= '0;
            bad      <= '0;
            fail_idx <= '1;
        end else begin
            done_q <= (state_n == DONE) && ((state != DONE) || go);
            if (go) begin
                mode_q <= (mode_i == 3'd7) ? 3'd6 : mode_i;
                runs_q <= runs_i;
                idx    <= '0;
                f1     <= '0;
                f2     <= FW'(1);
                lfsr   <= SEED;
                dcnt   <= '0;
            end else if (issue) begin
                enc_d <= data_n;
                mask  <= mask_n;
                idx   <= idx + 1'b1;
                f1    <= f1_n;
                f2    <= f2_n;
                lfsr  <= lfsr_n;
            end else if (state == DRAIN) begin
                dcnt <= dcnt + 1'b1;
            end
            if (go) begin
                good     <= '0;
                bad      <= '0;
                fail_idx <= '1;
            end else if (chk.valid) begin
                if (ok) begin
                    if (good != '1) good <= good + 1'b1;
                end else begin
                    if (bad != '1) bad <= bad + 1'b1;
                    if (bad == '0) fail_idx <= chk.idx;
                end
            end
        end
    end

    assign busy_o      = (state == RUN) || (state == DRAIN);
    assign done_o      = done_q;
    assign pass_o      = (state == DONE) && (bad == '0);
    assign good_o      = good;
    assign bad_o       = bad;
    assign fail_idx_o  = fail_idx;
    assign ecc.enc_d_o = enc_d;
    assign ecc.ch_q_o  = ecc.enc_q_i ^ mask;
endmodule

// File: tb/tb_ecc_bist.sv
// Directed bench: two engines (P0 at MSB with 2-stage decoder, P0 at
// LSB with combinational decoder) each wired to a behavioural codec.
module tb_ecc_bist;
    localparam int K = 72, M = 7, N = 79, CW = 80, RW = 24, CNTW = 32;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    typedef struct packed {
        logic sb; logic db; logic fix; logic [K-1:0] d;
    } dec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_start = 0, b_start = 0;
    logic [2:0]    a_mode = 0, b_mode = 0;
    logic [RW-1:0] a_runs = 0, b_runs = 0;
    logic          a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [CNTW-1:0] a_good, a_bad, b_good, b_bad;
    logic [RW-1:0] a_fidx, b_fidx;
    bit            fix0 = 0;
    int            n_cmp = 0, n_bad = 0;

    ecc_bist_if #(.K(K), .CW(CW)) ifa ();
    ecc_bist_if #(.K(K), .CW(CW)) ifb ();

    ecc_bist #(.K(K), .P0_LSB(0), .DEC_LATENCY(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .mode_i(a_mode),
        .runs_i(a_runs), .busy_o(a_busy), .done_o(a_done),
        .pass_o(a_pass), .good_o(a_good), .bad_o(a_bad),
        .fail_idx_o(a_fidx), .ecc(ifa));

    ecc_bist #(.K(K), .P0_LSB(1), .DEC_LATENCY(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .mode_i(b_mode),
        .runs_i(b_runs), .busy_o(b_busy), .done_o(b_done),
        .pass_o(b_pass), .good_o(b_good), .bad_o(b_bad),
        .fail_idx_o(b_fidx), .ecc(ifb));

    function automatic logic [CW-1:0] enc(input logic [K-1:0] d,
                                          input bit p0l);
        logic [N:0] h;
        logic [CW-1:0] cw;
        logic x;
        int j;
        h = '0;
        j = 0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin
                h[p] = d[j];
                j++;
            end
        for (int i = 0; i < M; i++) begin
            x = 1'b0;
            for (int p = 1; p <= N; p++)
                if (((p >> i) & 1) == 1) x ^= h[p];
            h[1 << i] = x;
        end
        cw = '0;
        for (int p = 1; p <= N; p++) cw[p0l ? p : p - 1] = h[p];
        cw[p0l ? 0 : N] = ^h[N:1];
        return cw;
    endfunction

    function automatic dec_t dec(input logic [CW-1:0] cw, input bit p0l);
        logic [N:0] h;
        logic par;
        int syn, j;
        dec_t r;
        h = '0;
        for (int p = 1; p <= N; p++) h[p] = cw[p0l ? p : p - 1];
        syn = 0;
        for (int p = 1; p <= N; p++) if (h[p]) syn ^= p;
        par = (^h[N:1]) ^ cw[p0l ? 0 : N];
        r = '0;
        if (par) begin
            r.sb = 1'b1;
            if (syn != 0 && syn <= N) begin
                h[syn] = ~h[syn];
                r.fix = ((syn & (syn - 1)) != 0);
            end
        end else if (syn != 0) begin
            r.db = 1'b1;
        end
        j = 0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin
                r.d[j] = h[p];
                j++;
            end
        return r;
    endfunction

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [K-1:0] rep(input logic [31:0] s);
        return {s[7:0], s, s};
    endfunction

    dec_t da_c, db_c, da_1 = '0, da_2 = '0;
    assign ifa.enc_q_i = enc(ifa.enc_d_o, 1'b0);
    assign da_c = dec(ifa.ch_q_o, 1'b0);
    always @(posedge clk) begin
        da_1 <= da_c;
        da_2 <= da_1;
    end
    assign ifa.dec_q_i  = da_2.d;
    assign ifa.sb_err_i = da_2.sb;
    assign ifa.db_err_i = da_2.db;
    assign ifa.sb_fix_i = da_2.fix & ~fix0;

    assign ifb.enc_q_i  = enc(ifb.enc_d_o, 1'b1);
    assign db_c = dec(ifb.ch_q_o, 1'b1);
    assign ifb.dec_q_i  = db_c.d;
    assign ifb.sb_err_i = db_c.sb;
    assign ifb.db_err_i = db_c.db;
    assign ifb.sb_fix_i = db_c.fix;

    // Starts one engine, follows it to DONE and checks issued words.
    task automatic run(input bit sel, input logic [2:0] mode,
                       input logic [RW-1:0] runs, input int nvec,
                       input bit rnd, input int poke,
                       output int bc, output int dc, output bit ps,
                       output int de);
        logic [31:0] lf;
        logic [K-1:0] exp_d, got_d;
        bit to;
        lf = SEED;
        @(negedge clk);
        if (sel) begin b_mode = mode; b_runs = runs; b_start = 1; end
        else     begin a_mode = mode; a_runs = runs; a_start = 1; end
        @(negedge clk);
        a_start = 0;
        b_start = 0;
        bc = 0; dc = 0; de = 0; to = 1;
        for (int c = 0; c < 20000; c++) begin
            if (!(sel ? b_busy : a_busy)) begin
                to = 0;
                break;
            end
            bc++;
            if (sel ? b_done : a_done) dc++;
            if (c >= 1 && c <= nvec) begin
                exp_d = rnd ? rep(lf) : K'(c - 1);
                got_d = sel ? ifb.enc_d_o : ifa.enc_d_o;
                if (got_d !== exp_d) de++;
                lf = step(lf);
            end
            if (c == poke) begin
                a_mode = 3'd0; a_runs = 5; a_start = 1;
            end
            if (c == poke + 1) a_start = 0;
            @(negedge clk);
        end
        if (to) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: busy=1 after 20000 cycles, want 0");
        end
        ps = sel ? b_pass : a_pass;
        if (sel ? b_done : a_done) dc++;
        @(negedge clk);
        if (sel ? b_done : a_done) dc++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        n_cmp++; if ({a_busy, a_done, a_pass} !== 3'b000) begin n_bad++;
            $display("FAIL rst flags: got %b, want 000", {a_busy, a_done, a_pass}); end
        n_cmp++; if (a_good !== 0 || a_bad !== 0) begin n_bad++;
            $display("FAIL rst counters: got %0d/%0d, want 0/0", a_good, a_bad); end
        n_cmp++; if (a_fidx !== 24'hFF_FFFF) begin n_bad++;
            $display("FAIL rst fail_idx: got %h, want ffffff", a_fidx); end
        n_cmp++; if (ifa.enc_d_o !== '0) begin n_bad++;
            $display("FAIL rst enc_d: got %h, want 0", ifa.enc_d_o); end
        n_cmp++; if (b_busy !== 0 || b_fidx !== 24'hFF_FFFF) begin n_bad++;
            $display("FAIL rst b: got busy %b idx %h, want 0 ffffff", b_busy, b_fidx); end
        rst_n = 1;
    endtask

    task automatic test_clean_seq();
        int bc, dc, de;
        bit ps;
        run(0, 3'd0, 72, 72, 0, -1, bc, dc, ps, de);
        n_cmp++; if (bc !== 75) begin n_bad++;
            $display("FAIL clean_seq busy: got %0d cycles, want 75", bc); end
        n_cmp++; if (dc !== 1) begin n_bad++;
            $display("FAIL clean_seq done: got %0d pulses, want 1", dc); end
        n_cmp++; if (a_good !== 72 || a_bad !== 0) begin n_bad++;
            $display("FAIL clean_seq counts: got %0d/%0d, want 72/0", a_good, a_bad); end
        n_cmp++; if (ps !== 1 || a_fidx !== 24'hFF_FFFF) begin n_bad++;
            $display("FAIL clean_seq pass: got %b idx %h, want 1 ffffff", ps, a_fidx); end
        n_cmp++; if (de !== 0) begin n_bad++;
            $display("FAIL clean_seq data: got %0d wrong words, want 0", de); end
        n_cmp++; if (ifa.enc_d_o !== K'(71)) begin n_bad++;
            $display("FAIL clean_seq last: got %0d, want 71", ifa.enc_d_o); end
    endtask

    task automatic test_one_bit_fault();
        int bc, dc, de;
        bit ps;
        fix0 = 1;
        run(0, 3'd2, 5, 80, 0, -1, bc, dc, ps, de);
        fix0 = 0;
        n_cmp++; if (bc !== 83) begin n_bad++;
            $display("FAIL 1b_fault busy: got %0d cycles, want 83", bc); end
        n_cmp++; if (a_good !== 8 || a_bad !== 72) begin n_bad++;
            $display("FAIL 1b_fault counts: got %0d/%0d, want 8/72", a_good, a_bad); end
        n_cmp++; if (a_fidx !== 24'd2) begin n_bad++;
            $display("FAIL 1b_fault fail_idx: got %0d, want 2", a_fidx); end
        n_cmp++; if (ps !== 0 || dc !== 1) begin n_bad++;
            $display("FAIL 1b_fault pass/done: got %b/%0d, want 0/1", ps, dc); end
        n_cmp++; if (de !== 0) begin n_bad++;
            $display("FAIL 1b_fault data: got %0d wrong words, want 0", de); end
    endtask

    task automatic test_rnd(input logic [2:0] mode);
        int bc, dc, de;
        bit ps;
        run(0, mode, 300, 300, 1, -1, bc, dc, ps, de);
        n_cmp++; if (a_good !== 300 || a_bad !== 0 || ps !== 1) begin n_bad++;
            $display("FAIL rnd mode %0d: got %0d/%0d pass %b, want 300/0 1",
                     mode, a_good, a_bad, ps); end
        n_cmp++; if (de !== 0 || bc !== 303) begin n_bad++;
            $display("FAIL rnd mode %0d seq: got %0d bad words %0d cycles, want 0 303",
                     mode, de, bc); end
    endtask

    task automatic test_two_bit_seq();
        int bc, dc, de;
        bit ps;
        run(0, 3'd4, 3, 6320, 0, -1, bc, dc, ps, de);
        n_cmp++; if (bc !== 6323) begin n_bad++;
            $display("FAIL 2b_seq busy: got %0d cycles, want 6323", bc); end
        n_cmp++; if (a_good !== 6320 || a_bad !== 0) begin n_bad++;
            $display("FAIL 2b_seq counts: got %0d/%0d, want 6320/0", a_good, a_bad); end
        n_cmp++; if (dc !== 1 || de !== 0) begin n_bad++;
            $display("FAIL 2b_seq done/data: got %0d/%0d, want 1/0", dc, de); end
    endtask

    task automatic test_mixed();
        int bc, dc, de;
        bit ps;
        for (int r = 0; r < 2; r++) begin
            run(1, (r == 0) ? 3'd6 : 3'd7, 3000, 3000, 1, -1, bc, dc, ps, de);
            n_cmp++; if (b_good !== 3000 || b_bad !== 0 || ps !== 1) begin n_bad++;
                $display("FAIL mixed run %0d: got %0d/%0d pass %b, want 3000/0 1",
                         r, b_good, b_bad, ps); end
            n_cmp++; if (de !== 0 || bc !== 3001) begin n_bad++;
                $display("FAIL mixed run %0d seq: got %0d bad words %0d cycles, want 0 3001",
                         r, de, bc); end
        end
    endtask

    task automatic test_start_ignored();
        int bc, dc, de;
        bit ps;
        run(0, 3'd1, 50, 50, 1, 10, bc, dc, ps, de);
        n_cmp++; if (a_good !== 50 || bc !== 53) begin n_bad++;
            $display("FAIL busy_start: got good %0d %0d cycles, want 50 53", a_good, bc); end
        n_cmp++; if (de !== 0) begin n_bad++;
            $display("FAIL busy_start data: got %0d wrong words, want 0", de); end
    endtask

    task automatic test_zero_runs();
        int bc, dc, de;
        bit ps;
        run(0, 3'd1, 0, 0, 1, -1, bc, dc, ps, de);
        n_cmp++; if (bc !== 0 || dc !== 1) begin n_bad++;
            $display("FAIL zero_runs timing: got busy %0d done %0d, want 0 1", bc, dc); end
        n_cmp++; if (ps !== 1 || a_good !== 0 || a_bad !== 0) begin n_bad++;
            $display("FAIL zero_runs result: got pass %b %0d/%0d, want 1 0/0",
                     ps, a_good, a_bad); end
    endtask

    task automatic test_reset_mid_run();
        int bc, dc, de;
        bit ps;
        @(negedge clk);
        a_mode = 3'd1; a_runs = 1000; a_start = 1;
        @(negedge clk);
        a_start = 0;
        repeat (20) @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_cmp++; if ({a_busy, a_done, a_pass} !== 3'b000) begin n_bad++;
            $display("FAIL midrst flags: got %b, want 000", {a_busy, a_done, a_pass}); end
        n_cmp++; if (a_good !== 0 || a_bad !== 0 || a_fidx !== 24'hFF_FFFF) begin n_bad++;
            $display("FAIL midrst counters: got %0d/%0d %h, want 0/0 ffffff",
                     a_good, a_bad, a_fidx); end
        n_cmp++; if (ifa.enc_d_o !== '0 || ifa.ch_q_o !== '0) begin n_bad++;
            $display("FAIL midrst bus: got %h %h, want 0 0", ifa.enc_d_o, ifa.ch_q_o); end
        @(negedge clk);
        rst_n = 1;
        run(0, 3'd0, 10, 10, 0, -1, bc, dc, ps, de);
        n_cmp++; if (a_good !== 10 || ps !== 1 || de !== 0) begin n_bad++;
            $display("FAIL midrst restart: got %0d pass %b data %0d, want 10 1 0",
                     a_good, ps, de); end
    endtask

    initial begin
        test_reset();
        test_clean_seq();
        test_one_bit_fault();
        test_rnd(3'd3);
        test_rnd(3'd5);
        test_two_bit_seq();
        test_mixed();
        test_start_ignored();
        test_zero_runs();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
